// File: rtl/mem_if_pkg.sv
// mem_if_pkg: shared definitions for the word-addressed memory interface responder.
// Provides the one-hot FSM state type, a constant clog2 helper and the legal
// SRAM read-latency range used by the top-level elaboration check.
package mem_if_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_ISSUE = 4'b0010,
    ST_WAIT  = 4'b0100,
    ST_ACK   = 4'b1000
  } mem_state_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  // Wide enough to hold RD_LAT_MAX-1.
  localparam int LAT_CNT_W = 2;

  // Ceiling log2, never below 1 so a derived address bus is always legal.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/mem_req_checker.sv
// mem_req_checker: combinational legality check for a memory request.
// Ports: addr/wr_en/rd_en from the initiator; legal=1 when exactly one of
// wr_en/rd_en is set and addr (full width) is below DEPTH.
module mem_req_checker
  import mem_if_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 1024
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic                  legal
);

  // One extra bit so DEPTH == 2**ADDR_WIDTH still compares correctly.
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

  logic op_ok;
  logic addr_ok;

  always_comb begin
    op_ok   = wr_en ^ rd_en;
    addr_ok = ({1'b0, addr} < DEPTH_EXT);
    legal   = op_ok & addr_ok;
  end

endmodule

// File: rtl/mem_sram_responder.sv
// mem_sram_responder: target end of the memory interface, one request at a time
// onto a single-port synchronous SRAM with RD_LATENCY read latency.
// Ports: clk/rst_n/soft_rst; mem_* request/ack handshake; sram_* macro pins.
// All outputs are flops: ack/err/rd_data only during ACK, sram_* only during ISSUE.
module mem_sram_responder
  import mem_if_pkg::*;
#(
  parameter int  DATA_WIDTH = 64,
  parameter int  ADDR_WIDTH = 32,
  parameter int  DEPTH      = 1024,
  parameter int  RD_LATENCY = 1,
  localparam int SRAM_AW    = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  soft_rst,
  input  logic                  mem_req_vld,
  output logic                  mem_ack_vld,
  output logic                  mem_err,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_wr_en,
  input  logic                  mem_rd_en,
  input  logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  sram_cs,
  output logic                  sram_we,
  output logic [SRAM_AW-1:0]    sram_addr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  input  logic [DATA_WIDTH-1:0] sram_rdata
);

  if (RD_LATENCY < RD_LAT_MIN || RD_LATENCY > RD_LAT_MAX) begin : g_bad_rd_latency
    $error("mem_sram_responder: RD_LATENCY=%0d outside %0d..%0d",
           RD_LATENCY, RD_LAT_MIN, RD_LAT_MAX);
  end

  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(RD_LATENCY - 1);

  mem_state_e             state_q,      state_d;
  logic                   wr_q,         wr_d;
  logic [LAT_CNT_W-1:0]   lat_cnt_q,    lat_cnt_d;
  logic                   ack_q,        ack_d;
  logic                   err_q,        err_d;
  logic [DATA_WIDTH-1:0]  rdata_q,      rdata_d;
  logic                   sram_cs_q,    sram_cs_d;
  logic                   sram_we_q,    sram_we_d;
  logic [SRAM_AW-1:0]     sram_addr_q,  sram_addr_d;
  logic [DATA_WIDTH-1:0]  sram_wdata_q, sram_wdata_d;

  logic req_legal;

  mem_req_checker #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_req_checker (
    .addr  (mem_addr),
    .wr_en (mem_wr_en),
    .rd_en (mem_rd_en),
    .legal (req_legal)
  );

  // Output flops are loaded with the value they must show in the *next* state,
  // so every output is a pure flop with no path from the mem_* inputs. The SRAM
  // address/data flops double as the latched request fields: they are loaded in
  // IDLE and only consumed during the single ISSUE cycle.
  always_comb begin
    state_d      = state_q;
    wr_d         = wr_q;
    lat_cnt_d    = lat_cnt_q;
    ack_d        = 1'b0;
    err_d        = 1'b0;
    rdata_d      = '0;
    sram_cs_d    = 1'b0;
    sram_we_d    = 1'b0;
    sram_addr_d  = '0;
    sram_wdata_d = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (mem_req_vld) begin
          wr_d = mem_wr_en;
          if (req_legal) begin
            state_d      = ST_ISSUE;
            sram_cs_d    = 1'b1;
            sram_we_d    = mem_wr_en;
            sram_addr_d  = mem_addr[SRAM_AW-1:0];
            sram_wdata_d = mem_wr_data;
          end else begin
            // Illegal requests never touch the SRAM.
            state_d = ST_ACK;
            ack_d   = 1'b1;
            err_d   = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (wr_q) begin
          state_d = ST_ACK;
          ack_d   = 1'b1;
        end else begin
          state_d   = ST_WAIT;
          lat_cnt_d = LAT_LOAD;
        end
      end
      ST_WAIT: begin
        if (lat_cnt_q == '0) begin
          state_d = ST_ACK;
          ack_d   = 1'b1;
          rdata_d = sram_rdata;
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end
      end
      ST_ACK: begin
        // Request valid is deliberately ignored here.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Soft reset aborts any transaction; a pending read result is dropped.
    if (soft_rst) begin
      state_d      = ST_IDLE;
      wr_d         = 1'b0;
      lat_cnt_d    = '0;
      ack_d        = 1'b0;
      err_d        = 1'b0;
      rdata_d      = '0;
      sram_cs_d    = 1'b0;
      sram_we_d    = 1'b0;
      sram_addr_d  = '0;
      sram_wdata_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      wr_q         <= 1'b0;
      lat_cnt_q    <= '0;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
      sram_cs_q    <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_q         <= wr_d;
      lat_cnt_q    <= lat_cnt_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
      sram_cs_q    <= sram_cs_d;
      sram_we_q    <= sram_we_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
    end
  end

  assign mem_ack_vld = ack_q;
  assign mem_err     = err_q;
  assign mem_rd_data = rdata_q;
  assign sram_cs     = sram_cs_q;
  assign sram_we     = sram_we_q;
  assign sram_addr   = sram_addr_q;
  assign sram_wdata  = sram_wdata_q;

endmodule
